// File: rtl/rx_event_monitor.sv
// Parallel receiver event counters with selectable registered readout and a windowed
// rate monitor that pulses receiver_rst. Optional snapshot bank: OPENOFDM_RX_EVENT_SNAPSHOT_EN.
module rx_event_monitor #(
  parameter int         N_EVENTS      = 8,
  parameter int         COUNTER_WIDTH = 22,
  parameter int         WINDOW_WIDTH  = 20,
  parameter int         SEL_WIDTH     = 5,
  parameter logic [4:0] CLEAR_ADDR    = 5'd17,
  parameter int         RST_PULSE_LEN = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_EVENTS-1:0]      event_in,
  input  logic [N_EVENTS-1:0]      event_mask,
  input  logic [SEL_WIDTH-1:0]     event_selector,
  output logic [COUNTER_WIDTH-1:0] event_counter,
  input  logic                     slv_reg_wren_signal,
  input  logic [4:0]               axi_awaddr_core,
  input  logic [SEL_WIDTH-1:0]     rate_event_sel,
  input  logic [WINDOW_WIDTH-1:0]  window_len,
  input  logic [15:0]              rate_th,
  output logic                     receiver_rst,
  output logic [7:0]               alarm_count
);

  localparam int N_SEL = 1 << SEL_WIDTH;
  localparam logic [3:0] PULSE_LAST = 4'(RST_PULSE_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_RST} state_t;

  logic                     clear_hit;
  logic [N_EVENTS-1:0]      count_en;
  logic [COUNTER_WIDTH-1:0] cnt_val [N_EVENTS];
  logic [COUNTER_WIDTH-1:0] src_val [N_EVENTS];
  logic [COUNTER_WIDTH-1:0] rd_val  [N_SEL];
  logic [N_SEL-1:0]         rate_hit_vec;
  logic [COUNTER_WIDTH-1:0] event_counter_reg;

  assign clear_hit = slv_reg_wren_signal && (axi_awaddr_core == CLEAR_ADDR);
  assign count_en  = {N_EVENTS{enable}} & event_in & ~event_mask;

  genvar gi;
  generate
    for (gi = 0; gi < N_EVENTS; gi++) begin : g_cnt
      logic [COUNTER_WIDTH-1:0] cnt_reg;
      // Clear has priority over a coincident strobe; counters saturate at all-ones.
      always_ff @(posedge clock) begin
        if (reset || clear_hit)
          cnt_reg <= '0;
        else if (count_en[gi] && (cnt_reg != '1))
          cnt_reg <= cnt_reg + 1'b1;
      end
      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

`ifdef OPENOFDM_RX_EVENT_SNAPSHOT_EN
  localparam logic [4:0] SNAP_ADDR = CLEAR_ADDR + 5'd1;
  logic snap_wr;
  assign snap_wr = slv_reg_wren_signal && (axi_awaddr_core == SNAP_ADDR);
  generate
    for (gi = 0; gi < N_EVENTS; gi++) begin : g_snap
      logic [COUNTER_WIDTH-1:0] snap_reg;
      always_ff @(posedge clock) begin
        if (reset)
          snap_reg <= '0;
        else if (snap_wr)
          snap_reg <= cnt_val[gi];
      end
      assign src_val[gi] = snap_reg;
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < N_EVENTS; gi++) begin : g_src
      assign src_val[gi] = cnt_val[gi];
    end
  endgenerate
`endif

  // Pad the selector space to a power of two so out-of-range selectors read 0 / never hit.
  generate
    for (gi = 0; gi < N_SEL; gi++) begin : g_rd
      if (gi < N_EVENTS) begin : g_live
        assign rd_val[gi]       = src_val[gi];
        assign rate_hit_vec[gi] = count_en[gi];
      end else begin : g_pad
        assign rd_val[gi]       = '0;
        assign rate_hit_vec[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset)
      event_counter_reg <= '0;
    else
      event_counter_reg <= rd_val[event_selector];
  end

  assign event_counter = event_counter_reg;

  state_t                  state_reg;
  logic [WINDOW_WIDTH-1:0] win_reg;
  logic [15:0]             rate_reg;
  logic [3:0]              pulse_reg;
  logic                    receiver_rst_reg;
  logic [7:0]              alarm_reg;
  logic                    run;
  logic [16:0]             rate_next;
  logic                    last_win;

  assign run       = enable && (window_len != '0) && (rate_th != '0);
  assign rate_next = {1'b0, rate_reg} + {16'd0, rate_hit_vec[rate_event_sel]};
  assign last_win  = win_reg >= (window_len - 1'b1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      win_reg          <= '0;
      rate_reg         <= '0;
      pulse_reg        <= '0;
      receiver_rst_reg <= 1'b0;
      alarm_reg        <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          win_reg  <= '0;
          rate_reg <= '0;
          if (run)
            state_reg <= S_COUNT;
        end
        S_COUNT: begin
          if (!run) begin
            state_reg <= S_IDLE;
            win_reg   <= '0;
            rate_reg  <= '0;
          end else if (rate_next >= {1'b0, rate_th}) begin
            // Alarm outranks a window restart on the same cycle.
            state_reg        <= S_RST;
            win_reg          <= '0;
            rate_reg         <= '0;
            pulse_reg        <= PULSE_LAST;
            receiver_rst_reg <= 1'b1;
            if (alarm_reg != 8'hFF)
              alarm_reg <= alarm_reg + 8'd1;
          end else if (last_win) begin
            win_reg  <= '0;
            rate_reg <= '0;
          end else begin
            win_reg  <= win_reg + 1'b1;
            rate_reg <= rate_next[15:0];
          end
        end
        S_RST: begin
          win_reg  <= '0;
          rate_reg <= '0;
          if (pulse_reg == 4'd0) begin
            receiver_rst_reg <= 1'b0;
            state_reg        <= run ? S_COUNT : S_IDLE;
          end else begin
            pulse_reg <= pulse_reg - 4'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign receiver_rst = receiver_rst_reg;
  assign alarm_count  = alarm_reg;

endmodule

// File: tb/tb_rx_event_monitor.sv
// Self-checking bench for rx_event_monitor: vector table, directed rate-monitor sequences
// and randomized traffic checked against a cycle-level reference model.
module tb_rx_event_monitor;

  localparam int N  = 8;
  localparam int CW = 4;
  localparam int PL = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  event_in;
  logic [N-1:0]  event_mask;
  logic [4:0]    event_selector;
  logic [CW-1:0] event_counter;
  logic          slv_reg_wren_signal;
  logic [4:0]    axi_awaddr_core;
  logic [4:0]    rate_event_sel;
  logic [19:0]   window_len;
  logic [15:0]   rate_th;
  logic          receiver_rst;
  logic [7:0]    alarm_count;

  always #5 clock = ~clock;

  rx_event_monitor #(
    .N_EVENTS(N), .COUNTER_WIDTH(CW), .WINDOW_WIDTH(20), .SEL_WIDTH(5),
    .CLEAR_ADDR(5'd17), .RST_PULSE_LEN(PL)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .event_in(event_in),
    .event_mask(event_mask), .event_selector(event_selector), .event_counter(event_counter),
    .slv_reg_wren_signal(slv_reg_wren_signal), .axi_awaddr_core(axi_awaddr_core),
    .rate_event_sel(rate_event_sel), .window_len(window_len), .rate_th(rate_th),
    .receiver_rst(receiver_rst), .alarm_count(alarm_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_cnt [N];
  int m_snap [N];
  int m_ec, m_alarm, m_pos, m_hits, m_pulse;
  bit m_rst, m_active;

  typedef struct {
    logic [7:0] ev;
    logic [7:0] mask;
    logic [4:0] sel;
    logic       wren;
    logic [4:0] addr;
    int         exp_ec;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  s;
    int  old_cnt [N];
    bit  hit, run;
    if (reset) begin
      foreach (m_cnt[i]) begin m_cnt[i] = 0; m_snap[i] = 0; end
      m_ec = 0; m_alarm = 0; m_pos = 0; m_hits = 0; m_pulse = 0; m_rst = 0; m_active = 0;
      return;
    end
    old_cnt = m_cnt;
    s = int'(event_selector);
`ifdef OPENOFDM_RX_EVENT_SNAPSHOT_EN
    m_ec = (s < N) ? m_snap[s] : 0;
    if (slv_reg_wren_signal && axi_awaddr_core == 5'd18) m_snap = old_cnt;
`else
    m_ec = (s < N) ? m_cnt[s] : 0;
`endif
    for (int i = 0; i < N; i++) begin
      if (slv_reg_wren_signal && axi_awaddr_core == 5'd17) m_cnt[i] = 0;
      else if (enable && event_in[i] && !event_mask[i]) m_cnt[i] = (old_cnt[i] + 1 > 15) ? 15 : old_cnt[i] + 1;
    end
    run = enable && window_len != 0 && rate_th != 0;
    hit = 0;
    if (enable && rate_event_sel < N) hit = event_in[rate_event_sel] && !event_mask[rate_event_sel];
    if (m_pulse > 0) begin
      m_pulse--;
      if (m_pulse == 0) m_active = run;
      m_pos = 0; m_hits = 0;
    end else if (m_active) begin
      if (!run) begin
        m_active = 0; m_pos = 0; m_hits = 0;
      end else begin
        m_hits += int'(hit);
        if (m_hits >= int'(rate_th)) begin
          m_pulse = PL; m_alarm = (m_alarm < 255) ? m_alarm + 1 : 255;
          m_active = 0; m_pos = 0; m_hits = 0;
        end else if (m_pos >= int'(window_len) - 1) begin
          m_pos = 0; m_hits = 0;
        end else begin
          m_pos++;
        end
      end
    end else if (run) begin
      m_active = 1; m_pos = 0; m_hits = 0;
    end
    m_rst = (m_pulse > 0);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    model_step();
    chk("event_counter", int'(event_counter), m_ec);
    chk("receiver_rst", int'(receiver_rst), int'(m_rst));
    chk("alarm_count", int'(alarm_count), m_alarm);
  endtask

  task automatic idle_inputs();
    event_in = '0; event_mask = '0; event_selector = '0;
    slv_reg_wren_signal = 1'b0; axi_awaddr_core = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    enable = 1'b0; window_len = '0; rate_th = '0; rate_event_sel = '0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    chk("reset_ec", int'(event_counter), 0);
    chk("reset_rst", int'(receiver_rst), 0);
    chk("reset_alarm", int'(alarm_count), 0);

    // Counting, readout, masking and clear vectors
    tbl.push_back('{8'h04, 8'h00, 5'd2, 1'b0, 5'd0,  0});
    tbl.push_back('{8'h04, 8'h00, 5'd2, 1'b0, 5'd0,  1});
    tbl.push_back('{8'h04, 8'h00, 5'd2, 1'b0, 5'd0,  2});
    tbl.push_back('{8'h04, 8'h00, 5'd2, 1'b0, 5'd0,  3});
    tbl.push_back('{8'h04, 8'h00, 5'd2, 1'b0, 5'd0,  4});
    tbl.push_back('{8'h00, 8'h00, 5'd2, 1'b0, 5'd0,  5});
    tbl.push_back('{8'h00, 8'h00, 5'd0, 1'b0, 5'd0,  0});
    tbl.push_back('{8'h00, 8'h00, 5'd3, 1'b0, 5'd0,  0});
    tbl.push_back('{8'h00, 8'h00, 5'd9, 1'b0, 5'd0,  0});
    tbl.push_back('{8'h04, 8'h04, 5'd2, 1'b0, 5'd0,  5});
    tbl.push_back('{8'h00, 8'h00, 5'd2, 1'b0, 5'd0,  5});
    tbl.push_back('{8'h04, 8'h00, 5'd2, 1'b1, 5'd16, 5});
    tbl.push_back('{8'h00, 8'h00, 5'd2, 1'b1, 5'd16, 6});
    tbl.push_back('{8'h04, 8'h00, 5'd2, 1'b1, 5'd17, 6});
    tbl.push_back('{8'h00, 8'h00, 5'd2, 1'b0, 5'd0,  0});
    enable = 1'b1;
    foreach (tbl[i]) begin
      event_in = tbl[i].ev; event_mask = tbl[i].mask; event_selector = tbl[i].sel;
      slv_reg_wren_signal = tbl[i].wren; axi_awaddr_core = tbl[i].addr;
      cycle();
      chk($sformatf("table_row%0d", i), int'(event_counter), tbl[i].exp_ec);
    end

    // Saturation, then clear coinciding with a strobe
    idle_inputs();
    event_in = 8'h01;
    repeat (20) cycle();
    event_in = 8'h00;
    cycle();
    chk("sat_hold", int'(event_counter), 15);
    event_in = 8'h01; slv_reg_wren_signal = 1'b1; axi_awaddr_core = 5'd17;
    cycle();
    idle_inputs();
    cycle();
    chk("clear_wins", int'(event_counter), 0);

    // Alarm after three strobes in one window
    do_reset();
    enable = 1'b1; window_len = 20'd100; rate_th = 16'd3; rate_event_sel = 5'd1;
    cycle();
    for (int c = 0; c < 40; c++) begin
      event_in = (c == 10 || c == 20 || c == 30) ? 8'h02 : 8'h00;
      cycle();
      chk("t3_rst", int'(receiver_rst), int'(c >= 30 && c <= 33));
    end
    chk("t3_alarm", int'(alarm_count), 1);

    // Two strobes per window never alarm; a third on the last window cycle does
    do_reset();
    cycle();
    for (int c = 0; c < 600; c++) begin
      event_in = ((c % 100) == 10 || (c % 100) == 50 || (c >= 500 && (c % 100) == 99)) ? 8'h02 : 8'h00;
      cycle();
      chk("t4_rst", int'(receiver_rst), int'(c == 599));
    end
    event_in = 8'h00;
    repeat (4) cycle();
    chk("t4_alarm", int'(alarm_count), 1);

    // Enable drop mid-pulse, then reset mid-pulse
    do_reset();
    rate_th = 16'd3;
    cycle();
    event_in = 8'h02;
    repeat (3) cycle();
    chk("t5_rise", int'(receiver_rst), 1);
    event_in = 8'h00; enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t5_hold", int'(receiver_rst), int'(k < 3));
    end
    event_in = 8'h02;
    repeat (3) cycle();
    chk("t5_idle", int'(receiver_rst), 0);
    event_in = 8'h00; enable = 1'b1;
    cycle();
    event_in = 8'h02;
    repeat (3) cycle();
    event_in = 8'h00;
    cycle();
    chk("t5_pulse2", int'(receiver_rst), 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_rst_drop", int'(receiver_rst), 0);
    chk("t5_alarm_clr", int'(alarm_count), 0);

    // Snapshot versus live readout
    window_len = '0;
    do_reset();
    event_selector = 5'd3;
    event_in = 8'h08;
    repeat (7) cycle();
    event_in = 8'h00; slv_reg_wren_signal = 1'b1; axi_awaddr_core = 5'd18;
    cycle();
    slv_reg_wren_signal = 1'b0; event_in = 8'h08;
    repeat (3) cycle();
    event_in = 8'h00;
    cycle();
`ifdef OPENOFDM_RX_EVENT_SNAPSHOT_EN
    chk("t6_snapshot", int'(event_counter), 7);
`else
    chk("t6_live", int'(event_counter), 10);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        window_len     = 20'($urandom_range(0, 12));
        rate_th        = 16'($urandom_range(0, 4));
        rate_event_sel = 5'($urandom_range(0, 9));
      end
      event_in            = 8'($urandom & $urandom);
      event_mask          = 8'($urandom & $urandom & $urandom);
      event_selector      = 5'($urandom_range(0, 9));
      slv_reg_wren_signal = ($urandom_range(0, 15) == 0);
      axi_awaddr_core     = 5'($urandom_range(16, 18));
      enable              = ($urandom_range(0, 19) != 0);
      reset               = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
